// File: rtl/gpio_out_sequencer.sv
// rtl/gpio_out_sequencer.sv - multi-channel GPIO output driver with static, blink and one-shot pulse modes
module gpio_out_sequencer #(
    parameter int CHANNELS  = 8,
    parameter int CH_WIDTH  = 3,
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 WR_EN,
    input  logic [CH_WIDTH-1:0]  WR_CH,
    input  logic [1:0]           WR_MODE,
    input  logic [CNT_WIDTH-1:0] WR_VALUE,
    output logic [CHANNELS-1:0]  GPIO_OUT,
    output logic [CHANNELS-1:0]  BUSY,
    output logic                 TICK
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_BLINK  = 2'd1,
        ST_PULSE  = 2'd2
    } state_t;

    logic [PW-1:0]        presc_q;
    logic                 tick;

    state_t               st_q  [CHANNELS];
    state_t               st_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CNT_WIDTH-1:0] rld_q [CHANNELS];
    logic [CNT_WIDTH-1:0] rld_d [CHANNELS];
    logic [CHANNELS-1:0]  out_q;
    logic [CHANNELS-1:0]  out_d;
    logic [CHANNELS-1:0]  busy_q;
    logic [CHANNELS-1:0]  busy_d;

    // Free-running timebase shared by all channels; writes never disturb it.
    assign tick = (presc_q == PW'(PRESCALE - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= ST_STATIC;
                cnt_q[i] <= '0;
                rld_q[i] <= '0;
            end
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                rld_q[i] <= rld_d[i];
            end
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    // A write to a channel takes priority over a coincident tick on that channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            rld_d[i] = rld_q[i];
            out_d[i] = out_q[i];
            if (WR_EN && (WR_CH == CH_WIDTH'(i))) begin
                st_d[i]  = ST_STATIC;
                cnt_d[i] = '0;
                rld_d[i] = '0;
                out_d[i] = 1'b0;
                case (WR_MODE)
                    2'b00: out_d[i] = WR_VALUE[0];
                    2'b01: begin
                        st_d[i]  = ST_BLINK;
                        out_d[i] = 1'b1;
                        rld_d[i] = (WR_VALUE == '0) ? CNT_WIDTH'(1) : WR_VALUE;
                        cnt_d[i] = (WR_VALUE == '0) ? CNT_WIDTH'(1) : WR_VALUE;
                    end
                    2'b10: begin
                        if (WR_VALUE != '0) begin
                            st_d[i]  = ST_PULSE;
                            out_d[i] = 1'b1;
                            rld_d[i] = WR_VALUE;
                            cnt_d[i] = WR_VALUE;
                        end
                    end
                    default: ;
                endcase
            end else if (tick) begin
                case (st_q[i])
                    ST_BLINK: begin
                        if (cnt_q[i] == CNT_WIDTH'(1)) begin
                            out_d[i] = ~out_q[i];
                            cnt_d[i] = rld_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q[i] == CNT_WIDTH'(1)) begin
                            out_d[i] = 1'b0;
                            st_d[i]  = ST_STATIC;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
            busy_d[i] = (st_d[i] != ST_STATIC);
        end
    end

    always_comb begin
        GPIO_OUT = out_q;
        BUSY     = busy_q;
        TICK     = tick;
    end

endmodule

// File: tb/tb_gpio_out_sequencer.sv
// tb/tb_gpio_out_sequencer.sv - scoreboard bench for gpio_out_sequencer (8- and 6-channel instances)
module tb_gpio_out_sequencer;

    logic        CLK;
    logic        RESET;
    logic        WR_EN;
    logic [2:0]  WR_CH;
    logic [1:0]  WR_MODE;
    logic [15:0] WR_VALUE;
    logic [7:0]  GPIO_OUT;
    logic [7:0]  BUSY;
    logic        TICK;
    logic [5:0]  gpio6;
    logic [5:0]  busy6;
    logic        tick6;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          q_cyc  [$];
    int          q_sel  [$];
    logic [15:0] q_exp  [$];
    logic [15:0] q_mask [$];
    string       q_name [$];

    gpio_out_sequencer #(.CHANNELS(8), .CH_WIDTH(3), .CNT_WIDTH(16), .PRESCALE(4)) dut (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_MODE(WR_MODE),
        .WR_VALUE(WR_VALUE), .GPIO_OUT(GPIO_OUT), .BUSY(BUSY), .TICK(TICK)
    );

    gpio_out_sequencer #(.CHANNELS(6), .CH_WIDTH(3), .CNT_WIDTH(16), .PRESCALE(4)) dut6 (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_MODE(WR_MODE),
        .WR_VALUE(WR_VALUE), .GPIO_OUT(gpio6), .BUSY(busy6), .TICK(tick6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // sel 0: 8-ch {BUSY,GPIO_OUT}; sel 1: {tick6,TICK}; sel 2: 6-ch {busy6,gpio6}
    task automatic push(input int off, input int sel, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] m, input string name);
        q_cyc.push_back(cyc + off);
        q_sel.push_back(sel);
        q_exp.push_back({b, g});
        q_mask.push_back({m, m});
        q_name.push_back(name);
    endtask

    task automatic push_tick(input int off, input logic t, input string name);
        push(off, 1, {6'b0, t, t}, 8'h00, 8'h03, name);
    endtask

    always @(negedge CLK) begin : monitor
        logic [15:0] act;
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                tests++;
                if (q_sel[i] == 0)      act = {BUSY, GPIO_OUT};
                else if (q_sel[i] == 1) act = {14'b0, tick6, TICK};
                else                    act = {2'b0, busy6, 2'b0, gpio6};
                if (q_cyc[i] < cyc) begin
                    fails++;
                    $display("FAIL %s: check for cycle %0d missed (now %0d)", q_name[i], q_cyc[i], cyc);
                end else if ((act & q_mask[i]) !== (q_exp[i] & q_mask[i])) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h (mask %h) at cycle %0d",
                             q_name[i], act & q_mask[i], q_exp[i] & q_mask[i], q_mask[i], cyc);
                end
                q_cyc.delete(i);
                q_sel.delete(i);
                q_exp.delete(i);
                q_mask.delete(i);
                q_name.delete(i);
            end
        end
    end

    task automatic wr(input int ch, input int mode, input int val);
        WR_EN    = 1'b1;
        WR_CH    = ch[2:0];
        WR_MODE  = mode[1:0];
        WR_VALUE = val[15:0];
        @(negedge CLK);
        WR_EN    = 1'b0;
        WR_CH    = '0;
        WR_MODE  = '0;
        WR_VALUE = '0;
    endtask

    // Returns at the negedge where TICK is high; the tick lands on the following edge.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (TICK) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_tick: TICK=0 for 16 cycles, required a strobe every 4");
        end
    endtask

    initial begin
        RESET    = 1'b1;
        WR_EN    = 1'b0;
        WR_CH    = '0;
        WR_MODE  = '0;
        WR_VALUE = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // reset while ch0 blinks
        push(1, 0, 8'h01, 8'h01, 8'h01, "blink_pre_reset");
        wr(0, 1, 1);
        repeat (6) @(negedge CLK);
        RESET = 1'b1;
        push(1, 0, 8'h00, 8'h00, 8'hff, "reset_c1");
        push_tick(1, 1'b0, "reset_tick");
        push(2, 0, 8'h00, 8'h00, 8'hff, "reset_c2");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // static
        push(1, 0, 8'h08, 8'h00, 8'h08, "static_set");
        wr(3, 0, 1);
        wait_tick();
        wait_tick();
        push(1, 0, 8'h08, 8'h00, 8'h08, "static_hold");
        @(negedge CLK);
        push(1, 0, 8'h00, 8'h00, 8'h08, "static_clr");
        wr(3, 0, 0);
        wait_tick();
        push(1, 0, 8'h00, 8'h00, 8'h08, "static_clr_hold");
        @(negedge CLK);

        // blink, half-period 2 ticks
        wait_tick();
        @(negedge CLK);
        push(1,  0, 8'h01, 8'h01, 8'h01, "blink2_load");
        push(7,  0, 8'h01, 8'h01, 8'h01, "blink2_pre_t1");
        push(8,  0, 8'h00, 8'h01, 8'h01, "blink2_t1");
        push(15, 0, 8'h00, 8'h01, 8'h01, "blink2_pre_t2");
        push(16, 0, 8'h01, 8'h01, 8'h01, "blink2_t2");
        push(24, 0, 8'h00, 8'h01, 8'h01, "blink2_t3");
        wr(0, 1, 2);
        repeat (25) @(negedge CLK);

        // blink, value 0 acts as 1
        wait_tick();
        @(negedge CLK);
        push(1, 0, 8'h01, 8'h01, 8'h01, "blink0_load");
        push(3, 0, 8'h01, 8'h01, 8'h01, "blink0_pre_t1");
        push(4, 0, 8'h00, 8'h01, 8'h01, "blink0_t1");
        push(7, 0, 8'h00, 8'h01, 8'h01, "blink0_pre_t2");
        push(8, 0, 8'h01, 8'h01, 8'h01, "blink0_t2");
        wr(0, 1, 0);
        repeat (8) @(negedge CLK);

        // pulse width 3
        wait_tick();
        @(negedge CLK);
        push(1,  0, 8'h20, 8'h20, 8'h20, "pulse3_load");
        push(11, 0, 8'h20, 8'h20, 8'h20, "pulse3_pre_end");
        push(12, 0, 8'h00, 8'h00, 8'h20, "pulse3_end");
        push(20, 0, 8'h00, 8'h00, 8'h20, "pulse3_idle");
        wr(5, 2, 3);
        repeat (20) @(negedge CLK);

        // pulse value 0 acts as static low, even while a pulse runs
        push(1, 0, 8'h20, 8'h20, 8'h20, "pulse5_load");
        push(2, 0, 8'h00, 8'h00, 8'h20, "pulse0_clear");
        wr(5, 2, 5);
        wr(5, 2, 0);
        repeat (2) @(negedge CLK);

        // write on ch1 coincident with a tick, ch2 blinking every tick
        wait_tick();
        @(negedge CLK);
        push(1, 0, 8'h04, 8'h04, 8'h04, "coll_ch2_load");
        wr(2, 1, 1);
        push_tick(1, 1'b0, "coll_tick_pre");
        push_tick(2, 1'b1, "coll_tick");
        repeat (2) @(negedge CLK);
        push(1, 0, 8'h02, 8'h06, 8'h06, "coll_first");
        push(5, 0, 8'h06, 8'h06, 8'h06, "coll_t2");
        push(8, 0, 8'h06, 8'h06, 8'h06, "coll_pre_end");
        push(9, 0, 8'h00, 8'h04, 8'h06, "coll_end");
        wr(1, 2, 2);
        repeat (9) @(negedge CLK);

        // out-of-range channel on the 6-channel instance, reserved mode mid-blink
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        wait_tick();
        @(negedge CLK);
        push(1, 2, 8'h04, 8'h04, 8'h3f, "oor_load");
        push(2, 0, 8'h80, 8'h80, 8'h80, "ch7_main");
        push(3, 2, 8'h04, 8'h04, 8'h3f, "oor_ignored");
        push(4, 2, 8'h00, 8'h04, 8'h3f, "oor_tick");
        push(8, 2, 8'h04, 8'h04, 8'h3f, "oor_pre_rsv");
        push(9, 2, 8'h00, 8'h00, 8'h3f, "rsv_dut6");
        push(9, 0, 8'h00, 8'h00, 8'h04, "rsv_main");
        wr(2, 1, 1);
        wr(7, 1, 3);
        wr(6, 0, 1);
        repeat (5) @(negedge CLK);
        wr(2, 3, 0);
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 50 && q_cyc.size() != 0; i++) @(negedge CLK);
        for (int i = 0; i < q_cyc.size(); i++) begin
            tests++;
            fails++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", q_name[i], q_cyc[i], cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
